// File: rtl/dlta_pkg.sv
// -----------------------------------------------------------------------------
// dlta_pkg
// Shared definitions for the ICAP multiboot sequencer:
//   - state_t           : sequencer FSM states
//   - ICAP word constants (sync word, register headers, IPROG command, NOOP,
//     dummy/pad byte)
//   - SEQ_LEN_BASE      : command length when the golden fallback is not built
//   - SEQ_LEN_GOLDEN    : command length with the golden fallback registers
// The optional golden fallback is selected with the GOLDEN_FALLBACK_EN macro.
// -----------------------------------------------------------------------------
package dlta_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]  DUMMY        = 8'hFF;
    localparam logic [7:0]  SYNC_HI      = 8'hAA;
    localparam logic [7:0]  SYNC_LO      = 8'h99;

    // Type-1 write headers, one word each
    localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
    localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
    localparam logic [15:0] HDR_GENERAL3 = 16'h32A1;
    localparam logic [15:0] HDR_GENERAL4 = 16'h32C1;
    localparam logic [15:0] HDR_CMD      = 16'h30A1;

    localparam logic [15:0] CMD_IPROG    = 16'h000E;
    localparam logic [15:0] NOOP         = 16'h2000;

    localparam int SEQ_LEN_BASE   = 26;
    localparam int SEQ_LEN_GOLDEN = 34;

`ifdef GOLDEN_FALLBACK_EN
    localparam int SEQ_LEN = SEQ_LEN_GOLDEN;
`else
    localparam int SEQ_LEN = SEQ_LEN_BASE;
`endif

endpackage

// File: rtl/dlta_icap_seq_rom.sv
// -----------------------------------------------------------------------------
// dlta_icap_seq_rom
// Combinational lookup of the byte-serial IPROG command sequence (raw byte
// order, no bit reversal).
// Ports:
//   index           in  6  byte position in the sequence
//   sector          in  4  multiboot sector, placed in GENERAL2 data bits 7:4
//   fallback_sector in  4  golden sector for GENERAL4 (GOLDEN_FALLBACK_EN only)
//   data            out 8  raw sequence byte, 00 past the end
//   valid           out 1  index lies inside the sequence
// Macro: GOLDEN_FALLBACK_EN inserts GENERAL3/GENERAL4 before the CMD word.
// -----------------------------------------------------------------------------
module dlta_icap_seq_rom
    import dlta_pkg::*;
(
    input  logic [5:0] index,
    input  logic [3:0] sector,
`ifdef GOLDEN_FALLBACK_EN
    input  logic [3:0] fallback_sector,
`endif
    output logic [7:0] data,
    output logic       valid
);

`ifdef GOLDEN_FALLBACK_EN
    localparam int CMD_AT = 24;
`else
    localparam int CMD_AT = 16;
`endif

    always_comb begin
        data  = DUMMY;
        valid = (index < 6'(SEQ_LEN));
        case (index)
            6'd6:  data = SYNC_HI;
            6'd7:  data = SYNC_LO;
            6'd8:  data = HDR_GENERAL1[15:8];
            6'd9:  data = HDR_GENERAL1[7:0];
            6'd10: data = 8'h00;
            6'd11: data = 8'h00;
            6'd12: data = HDR_GENERAL2[15:8];
            6'd13: data = HDR_GENERAL2[7:0];
            6'd14: data = 8'h00;
            // Flash address bits 23:20 land in the upper nibble
            6'd15: data = {sector, 4'h0};
`ifdef GOLDEN_FALLBACK_EN
            6'd16: data = HDR_GENERAL3[15:8];
            6'd17: data = HDR_GENERAL3[7:0];
            6'd18: data = 8'h00;
            6'd19: data = 8'h00;
            6'd20: data = HDR_GENERAL4[15:8];
            6'd21: data = HDR_GENERAL4[7:0];
            6'd22: data = 8'h00;
            6'd23: data = {fallback_sector, 4'h0};
`endif
            6'(CMD_AT + 0): data = HDR_CMD[15:8];
            6'(CMD_AT + 1): data = HDR_CMD[7:0];
            6'(CMD_AT + 2): data = CMD_IPROG[15:8];
            6'(CMD_AT + 3): data = CMD_IPROG[7:0];
            6'(CMD_AT + 4): data = NOOP[15:8];
            6'(CMD_AT + 5): data = NOOP[7:0];
            6'(CMD_AT + 6): data = NOOP[15:8];
            6'(CMD_AT + 7): data = NOOP[7:0];
            // Leading pad bytes and the two trailing pad bytes
            default:        data = DUMMY;
        endcase
        if (!valid) begin
            data = 8'h00;
        end
    end

endmodule

// File: rtl/dlta_reboot_sequencer.sv
// -----------------------------------------------------------------------------
// dlta_reboot_sequencer
// Arbitrated multiboot controller for the Spartan-3A ICAP port. A host and a
// local requester compete for a reboot; the winner must hold its request for
// HOLDOFF cycles, after which the IPROG sequence is streamed into ICAP one
// byte per cycle. Once streaming starts the sequence is committed.
// Parameters:
//   HOLDOFF          cycles a granted request must stay high (min 2)
// Ports:
//   CLK              in  1  system clock
//   RST              in  1  asynchronous active-high reset
//   HOST_REQ         in  1  host reboot request (level)
//   HOST_SECTOR      in  4  host target sector
//   LOCAL_REQ        in  1  local reboot request (level)
//   LOCAL_SECTOR     in  4  local target sector
//   FALLBACK_SECTOR  in  4  golden sector (GOLDEN_FALLBACK_EN only)
//   ICAP_CE          out 1  ICAP chip enable, active low
//   ICAP_WRITE       out 1  ICAP write select, 0 = write
//   ICAP_I           out 8  ICAP data, bit-reversed per byte
//   BUSY             out 1  high in every state except IDLE
//   GRANT            out 2  one-hot owner, bit0 host, bit1 local
// Macro: GOLDEN_FALLBACK_EN adds the FALLBACK_SECTOR port and the golden
// fallback registers in the sequence.
// -----------------------------------------------------------------------------
module dlta_reboot_sequencer
    import dlta_pkg::*;
#(
    parameter int HOLDOFF = 2**24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HOST_REQ,
    input  logic [3:0] HOST_SECTOR,
    input  logic       LOCAL_REQ,
    input  logic [3:0] LOCAL_SECTOR,
`ifdef GOLDEN_FALLBACK_EN
    input  logic [3:0] FALLBACK_SECTOR,
`endif
    output logic       ICAP_CE,
    output logic       ICAP_WRITE,
    output logic [7:0] ICAP_I,
    output logic       BUSY,
    output logic [1:0] GRANT
);

    localparam int              HW        = $clog2(HOLDOFF);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLDOFF - 1);

    state_t         state;
    logic [HW-1:0]  hold_cnt;
    logic [5:0]     idx;        // index of the next byte to drive
    logic [3:0]     sector_q;

    logic           granted_req;
    logic [3:0]     granted_sector;
    logic [3:0]     rom_sector;
    logic [7:0]     rom_data;
    logic           rom_valid;

    // ICAP expects bit 0 of each configuration byte on data pin 7
    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    assign granted_req    = GRANT[0] ? HOST_REQ    : LOCAL_REQ;
    assign granted_sector = GRANT[0] ? HOST_SECTOR : LOCAL_SECTOR;

    // Byte 0 is driven on the ARM->STREAM edge, before sector_q is loaded
    assign rom_sector = (state == S_ARM) ? granted_sector : sector_q;

    dlta_icap_seq_rom u_rom (
        .index           (idx),
        .sector          (rom_sector),
`ifdef GOLDEN_FALLBACK_EN
        .fallback_sector (FALLBACK_SECTOR),
`endif
        .data            (rom_data),
        .valid           (rom_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            idx        <= '0;
            sector_q   <= '0;
            ICAP_CE    <= 1'b1;
            ICAP_WRITE <= 1'b1;
            ICAP_I     <= 8'h00;
            BUSY       <= 1'b0;
            GRANT      <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (HOST_REQ || LOCAL_REQ) begin
                        // Host has priority on simultaneous requests
                        GRANT    <= HOST_REQ ? 2'b01 : 2'b10;
                        BUSY     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= S_ARM;
                    end
                end

                S_ARM: begin
                    // A drop always cancels, even on the terminal count
                    if (!granted_req) begin
                        GRANT    <= 2'b00;
                        BUSY     <= 1'b0;
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        sector_q   <= granted_sector;
                        ICAP_CE    <= 1'b0;
                        ICAP_WRITE <= 1'b0;
                        ICAP_I     <= bit_reverse(rom_data);
                        idx        <= idx + 6'd1;
                        state      <= S_STREAM;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                S_STREAM: begin
                    if (rom_valid) begin
                        ICAP_I <= bit_reverse(rom_data);
                        idx    <= idx + 6'd1;
                    end else begin
                        // idx stays at SEQ_LEN from here on
                        ICAP_CE    <= 1'b1;
                        ICAP_WRITE <= 1'b1;
                        ICAP_I     <= 8'h00;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Terminal until reset; the device reconfigures from here
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlta_reboot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dlta_reboot_sequencer
// Directed bench for dlta_reboot_sequencer with HOLDOFF=4. Each scenario task
// drives its stimulus and checks outputs one time unit after the rising edge.
// Macro: GOLDEN_FALLBACK_EN enables the golden fallback scenario.
// -----------------------------------------------------------------------------
module tb_dlta_reboot_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       HOST_REQ = 1'b0;
    logic [3:0] HOST_SECTOR = 4'h0;
    logic       LOCAL_REQ = 1'b0;
    logic [3:0] LOCAL_SECTOR = 4'h0;
`ifdef GOLDEN_FALLBACK_EN
    logic [3:0] FALLBACK_SECTOR = 4'h0;
`endif
    logic       ICAP_CE;
    logic       ICAP_WRITE;
    logic [7:0] ICAP_I;
    logic       BUSY;
    logic [1:0] GRANT;

    int checks = 0;
    int passed = 0;

    dlta_reboot_sequencer #(.HOLDOFF(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .HOST_REQ        (HOST_REQ),
        .HOST_SECTOR     (HOST_SECTOR),
        .LOCAL_REQ       (LOCAL_REQ),
        .LOCAL_SECTOR    (LOCAL_SECTOR),
`ifdef GOLDEN_FALLBACK_EN
        .FALLBACK_SECTOR (FALLBACK_SECTOR),
`endif
        .ICAP_CE         (ICAP_CE),
        .ICAP_WRITE      (ICAP_WRITE),
        .ICAP_I          (ICAP_I),
        .BUSY            (BUSY),
        .GRANT           (GRANT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7 - b];
        return r;
    endfunction

    // Hand-written base sequence (26 bytes, raw order)
    function automatic logic [7:0] exp_raw(input int k, input logic [3:0] s);
        case (k)
            0, 1, 2, 3, 4, 5: return 8'hFF;
            6:  return 8'hAA;
            7:  return 8'h99;
            8:  return 8'h32;
            9:  return 8'h61;
            10: return 8'h00;
            11: return 8'h00;
            12: return 8'h32;
            13: return 8'h81;
            14: return 8'h00;
            15: return {s, 4'h0};
            16: return 8'h30;
            17: return 8'hA1;
            18: return 8'h00;
            19: return 8'h0E;
            20: return 8'h20;
            21: return 8'h00;
            22: return 8'h20;
            23: return 8'h00;
            24, 25: return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_reset();
        HOST_REQ  = 1'b0;
        LOCAL_REQ = 1'b0;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++;
        if ({ICAP_CE, ICAP_WRITE, ICAP_I, BUSY, GRANT} !== {1'b1, 1'b1, 8'h00, 1'b0, 2'b00})
            $display("FAIL reset_values got ce=%b wr=%b i=%h busy=%b grant=%b want 1 1 00 0 00",
                     ICAP_CE, ICAP_WRITE, ICAP_I, BUSY, GRANT);
        else passed++;
        RST = 1'b0;
        step();
        step();
        checks++;
        if ({ICAP_CE, BUSY, GRANT} !== {1'b1, 1'b0, 2'b00})
            $display("FAIL idle_after_release got ce=%b busy=%b grant=%b want 1 0 00",
                     ICAP_CE, BUSY, GRANT);
        else passed++;
    endtask

    task automatic test_local_stream();
        LOCAL_SECTOR = 4'h3;
        LOCAL_REQ = 1'b1;
        step();
        checks++;
        if (GRANT !== 2'b10 || BUSY !== 1'b1 || ICAP_CE !== 1'b1)
            $display("FAIL local_grant got grant=%b busy=%b ce=%b want 10 1 1", GRANT, BUSY, ICAP_CE);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ICAP_CE !== 1'b1) $display("FAIL local_holdoff%0d got ce=%b want 1", i, ICAP_CE);
            else passed++;
        end
        step();
        for (int k = 0; k < 26; k++) begin
            checks++;
            if (ICAP_CE !== 1'b0 || ICAP_WRITE !== 1'b0 || ICAP_I !== rev8(exp_raw(k, 4'h3)))
                $display("FAIL local_byte%0d got ce=%b wr=%b i=%h want 0 0 %h",
                         k, ICAP_CE, ICAP_WRITE, ICAP_I, rev8(exp_raw(k, 4'h3)));
            else passed++;
            if (k == 15) begin
                checks++;
                if (ICAP_I !== 8'h0C) $display("FAIL local_sector_byte got %h want 0c", ICAP_I);
                else passed++;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ICAP_CE, ICAP_WRITE, BUSY, GRANT} !== {1'b1, 1'b1, 1'b1, 2'b10})
                $display("FAIL local_done%0d got ce=%b wr=%b busy=%b grant=%b want 1 1 1 10",
                         i, ICAP_CE, ICAP_WRITE, BUSY, GRANT);
            else passed++;
            step();
        end
        do_reset();
    endtask

    task automatic test_simultaneous();
        HOST_SECTOR  = 4'hA;
        LOCAL_SECTOR = 4'h5;
        HOST_REQ  = 1'b1;
        LOCAL_REQ = 1'b1;
        step();
        checks++;
        if (GRANT !== 2'b01 || BUSY !== 1'b1)
            $display("FAIL simul_grant got grant=%b busy=%b want 01 1", GRANT, BUSY);
        else passed++;
        repeat (4) step();
        // Now on byte 0; advance to byte 15
        repeat (15) step();
        checks++;
        if (ICAP_CE !== 1'b0 || ICAP_I !== 8'h05)
            $display("FAIL simul_sector_byte got ce=%b i=%h want 0 05", ICAP_CE, ICAP_I);
        else passed++;
        do_reset();
    endtask

    task automatic test_cancel_early();
        HOST_SECTOR = 4'h2;
        HOST_REQ = 1'b1;
        step();
        step();
        HOST_REQ = 1'b0;
        step();
        checks++;
        if ({GRANT, BUSY, ICAP_CE} !== {2'b00, 1'b0, 1'b1})
            $display("FAIL cancel_early got grant=%b busy=%b ce=%b want 00 0 1", GRANT, BUSY, ICAP_CE);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (ICAP_CE !== 1'b1 || BUSY !== 1'b0)
                $display("FAIL cancel_idle%0d got ce=%b busy=%b want 1 0", i, ICAP_CE, BUSY);
            else passed++;
        end
    endtask

    task automatic test_cancel_late();
        HOST_REQ = 1'b1;
        step();
        repeat (3) step();
        // Counter is at HOLDOFF-1; dropping now must still cancel
        HOST_REQ = 1'b0;
        step();
        checks++;
        if ({GRANT, BUSY, ICAP_CE} !== {2'b00, 1'b0, 1'b1})
            $display("FAIL cancel_late got grant=%b busy=%b ce=%b want 00 0 1", GRANT, BUSY, ICAP_CE);
        else passed++;
        step();
        checks++;
        if (ICAP_CE !== 1'b1) $display("FAIL cancel_late_ce got %b want 1", ICAP_CE);
        else passed++;
    endtask

    task automatic test_stream_commit();
        LOCAL_SECTOR = 4'h6;
        LOCAL_REQ = 1'b1;
        step();
        HOST_REQ = 1'b1;
        step();
        checks++;
        if (GRANT !== 2'b10) $display("FAIL commit_arm_grant got %b want 10", GRANT);
        else passed++;
        HOST_REQ = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 26; k++) begin
            HOST_SECTOR  = 4'(k);
            LOCAL_SECTOR = ~4'(k);
            HOST_REQ     = k[0];
            LOCAL_REQ    = k[1];
            checks++;
            if (ICAP_CE !== 1'b0 || ICAP_I !== rev8(exp_raw(k, 4'h6)))
                $display("FAIL commit_byte%0d got ce=%b i=%h want 0 %h",
                         k, ICAP_CE, ICAP_I, rev8(exp_raw(k, 4'h6)));
            else passed++;
            step();
        end
        checks++;
        if ({ICAP_CE, BUSY, GRANT} !== {1'b1, 1'b1, 2'b10})
            $display("FAIL commit_done got ce=%b busy=%b grant=%b want 1 1 10", ICAP_CE, BUSY, GRANT);
        else passed++;
        do_reset();
    endtask

    task automatic test_reset_mid_stream();
        HOST_SECTOR = 4'h5;
        HOST_REQ = 1'b1;
        step();
        repeat (4) step();
        repeat (10) step();
        checks++;
        if (ICAP_CE !== 1'b0 || ICAP_I !== 8'h00)
            $display("FAIL midrst_byte10 got ce=%b i=%h want 0 00", ICAP_CE, ICAP_I);
        else passed++;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({ICAP_CE, ICAP_WRITE, ICAP_I, BUSY, GRANT} !== {1'b1, 1'b1, 8'h00, 1'b0, 2'b00})
            $display("FAIL midrst_async got ce=%b wr=%b i=%h busy=%b grant=%b want 1 1 00 0 00",
                     ICAP_CE, ICAP_WRITE, ICAP_I, BUSY, GRANT);
        else passed++;
        do_reset();
    endtask

`ifdef GOLDEN_FALLBACK_EN
    function automatic logic [7:0] exp_golden(input int k, input logic [3:0] s, input logic [3:0] fb);
        case (k)
            16: return 8'h32;
            17: return 8'hA1;
            18: return 8'h00;
            19: return 8'h00;
            20: return 8'h32;
            21: return 8'hC1;
            22: return 8'h00;
            23: return {fb, 4'h0};
            default: return (k >= 24) ? exp_raw(k - 8, s) : exp_raw(k, s);
        endcase
    endfunction

    task automatic test_golden();
        FALLBACK_SECTOR = 4'h1;
        HOST_SECTOR = 4'h7;
        HOST_REQ = 1'b1;
        step();
        repeat (4) step();
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (ICAP_CE !== 1'b0 || ICAP_I !== rev8(exp_golden(k, 4'h7, 4'h1)))
                $display("FAIL golden_byte%0d got ce=%b i=%h want 0 %h",
                         k, ICAP_CE, ICAP_I, rev8(exp_golden(k, 4'h7, 4'h1)));
            else passed++;
            if (k == 23) begin
                checks++;
                if (ICAP_I !== 8'h08) $display("FAIL golden_fb_byte got %h want 08", ICAP_I);
                else passed++;
            end
            if (k == 24) begin
                checks++;
                if (ICAP_I !== 8'h0C) $display("FAIL golden_cmd_at24 got %h want 0c", ICAP_I);
                else passed++;
            end
            step();
        end
        checks++;
        if (ICAP_CE !== 1'b1) $display("FAIL golden_done got ce=%b want 1", ICAP_CE);
        else passed++;
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_local_stream();
        test_simultaneous();
        test_cancel_early();
        test_cancel_late();
        test_stream_commit();
        test_reset_mid_stream();
`ifdef GOLDEN_FALLBACK_EN
        test_golden();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
